// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   state_e    : controller states
//   off_bits / idx_bits / tag_bits / way_bits : address and way field widths
//   line_addr  : rebuilds a line-aligned word address from tag and index
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVICT    = 3'd1,
    ST_FILL     = 3'd2,
    ST_RESPOND  = 3'd3,
    ST_WT_WRITE = 3'd4
  } state_e;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int word_size, input int line_words, input int sets);
    return word_size - off_bits(line_words) - idx_bits(sets);
  endfunction

  // A direct-mapped build still needs a 1-bit way select to declare vectors.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Offset bits come out as zero; works when the index field is empty (ib = 0).
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx,
                                            input int ob, input int ib);
    return (tag << (ob + ib)) | (idx << ob);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: one age per way per set, 0 = most recently used.
//   clk, reset_n : clock, synchronous active-low reset (way w starts at age w)
//   index        : set being accessed
//   touch_way    : way to mark most recently used when touch_en=1
//   valid_mask   : valid bits of the indexed set
//   victim_way   : lowest-numbered invalid way, else the oldest way
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = 4,
  parameter int WAYS = 2,
  parameter int IW   = (idx_bits(SETS) > 0) ? idx_bits(SETS) : 1,
  parameter int WW   = way_bits(WAYS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IW-1:0]   index,
  input  logic [WW-1:0]   touch_way,
  input  logic            touch_en,
  input  logic [WAYS-1:0] valid_mask,
  output logic [WW-1:0]   victim_way
);

  logic [WW-1:0] age_q [SETS][WAYS];

  // Ages in a set always form a permutation of 0..WAYS-1: the touched way drops
  // to 0 and only the ways younger than it move up by one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WW'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == touch_way)
          age_q[index][w] <= '0;
        else if (age_q[index][w] < age_q[index][touch_way])
          age_q[index][w] <= age_q[index][w] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins the last assignment.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[index][w] == WW'(WAYS - 1)) victim_way = WW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_mask[w]) victim_way = WW'(w);
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative cache between the CPU pipeline and line-wide memory.
//   CPU side   : cpu_read/cpu_write/cpu_addr/cpu_wdata in; cpu_rdata/cpu_ready/hit out
//   stall      : freezes hit-path updates while in IDLE
//   memory side: mem_read/mem_write/mem_addr/mem_wdata out; mem_rdata/mem_ack in
//   busy       : a memory transaction (evict, fill, write-through) is in flight
// Hits complete combinationally in IDLE; misses go EVICT (dirty victim) -> FILL
// -> RESPOND. Write-through mode routes every write through WT_WRITE.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int WRITE_BACK = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             stall,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  input  logic [WORD_SIZE-1:0]             cpu_addr,
  input  logic [WORD_SIZE-1:0]             cpu_wdata,
  output logic [WORD_SIZE-1:0]             cpu_rdata,
  output logic                             cpu_ready,
  output logic                             hit,
  output logic                             busy,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [LINE_WORDS*WORD_SIZE-1:0]  mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_rdata,
  input  logic                             mem_ack
);

  localparam int OB = off_bits(LINE_WORDS);
  localparam int IB = idx_bits(SETS);
  localparam int IW = (IB > 0) ? IB : 1;
  localparam int TB = tag_bits(WORD_SIZE, LINE_WORDS, SETS);
  localparam int WW = way_bits(WAYS);
  localparam int LW = LINE_WORDS * WORD_SIZE;
  localparam bit WB = (WRITE_BACK != 0);

  typedef logic [LW-1:0] line_t;

  // Storage
  line_t           data_q  [SETS][WAYS];
  logic [TB-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];

  state_e          state_q, state_d;
  logic [WW-1:0]   way_q, way_d;

  // Request decode; the CPU holds the request steady until it completes.
  logic            req, is_wr;
  logic [OB-1:0]   req_off;
  logic [IW-1:0]   req_idx;
  logic [TB-1:0]   req_tag;
  logic [WORD_SIZE-1:0] req_line_addr;

  assign req     = cpu_read | cpu_write;
  assign is_wr   = cpu_write;
  assign req_off = cpu_addr[OB-1:0];
  assign req_idx = IW'((cpu_addr >> OB) & WORD_SIZE'(SETS - 1));
  assign req_tag = TB'(cpu_addr >> (OB + IB));
  assign req_line_addr = WORD_SIZE'(line_addr(32'(req_tag), 32'(req_idx), OB, IB));

  function automatic logic [WORD_SIZE-1:0] word_of(input line_t line, input logic [OB-1:0] off);
    return line[int'(off)*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic line_t merge(input line_t line, input logic [OB-1:0] off,
                                  input logic [WORD_SIZE-1:0] w);
    line_t m;
    m = line;
    m[int'(off)*WORD_SIZE +: WORD_SIZE] = w;
    return m;
  endfunction

  // Tag compare across the indexed set
  logic          hit_any;
  logic [WW-1:0] hit_way;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Replacement
  logic [WW-1:0] victim_way, lru_way;
  logic          lru_touch;

  cache_lru #(.SETS(SETS), .WAYS(WAYS), .IW(IW), .WW(WW)) u_lru (
    .clk        (clk),
    .reset_n    (reset_n),
    .index      (req_idx),
    .touch_way  (lru_way),
    .touch_en   (lru_touch),
    .valid_mask (valid_q[req_idx]),
    .victim_way (victim_way)
  );

  // Next-state and outputs
  logic          data_we, install, fill_dirty, set_dirty, clr_dirty;
  logic [WW-1:0] data_way;
  line_t         data_line;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    way_d      = way_q;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    hit        = 1'b0;
    busy       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lru_touch  = 1'b0;
    lru_way    = way_q;
    data_we    = 1'b0;
    data_way   = way_q;
    data_line  = '0;
    install    = 1'b0;
    fill_dirty = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req && hit_any) begin
          hit       = 1'b1;
          cpu_rdata = word_of(data_q[req_idx][hit_way], req_off);
          // A write-through write is not done until memory has it.
          cpu_ready = !(is_wr && !WB);
          if (!stall) begin
            lru_touch = 1'b1;
            lru_way   = hit_way;
            way_d     = hit_way;
            if (is_wr) begin
              data_we   = 1'b1;
              data_way  = hit_way;
              data_line = merge(data_q[req_idx][hit_way], req_off, cpu_wdata);
              if (WB) set_dirty = 1'b1;
              else    state_d   = ST_WT_WRITE;
            end
          end
        end else if (req && !stall) begin
          way_d   = victim_way;
          state_d = (WB && valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way])
                    ? ST_EVICT : ST_FILL;
        end
      end

      ST_EVICT: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = WORD_SIZE'(line_addr(32'(tag_q[req_idx][way_q]), 32'(req_idx), OB, IB));
        mem_wdata = data_q[req_idx][way_q];
        if (mem_ack) begin
          clr_dirty = 1'b1;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = req_line_addr;
        if (mem_ack) begin
          data_we    = 1'b1;
          data_line  = is_wr ? merge(mem_rdata, req_off, cpu_wdata) : mem_rdata;
          install    = 1'b1;
          fill_dirty = is_wr && WB;
          lru_touch  = 1'b1;
          state_d    = (is_wr && !WB) ? ST_WT_WRITE : ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = word_of(data_q[req_idx][way_q], req_off);
        state_d   = ST_IDLE;
      end

      ST_WT_WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = req_line_addr;
        mem_wdata = data_q[req_idx][way_q];
        if (mem_ack) state_d = ST_RESPOND;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: reset clears every valid/dirty bit and abandons any transaction.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      way_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      if (install) begin
        valid_q[req_idx][way_q] <= 1'b1;
        dirty_q[req_idx][way_q] <= fill_dirty;
      end
      if (set_dirty) dirty_q[req_idx][hit_way] <= 1'b1;
      if (clr_dirty) dirty_q[req_idx][way_q]   <= 1'b0;
    end
  end

  // NOTE: data and tag arrays carry no reset; a line is only observable once its
  // valid bit is set, so resetting the array would add cost without effect.
  always_ff @(posedge clk) begin
    if (data_we) data_q[req_idx][data_way] <= data_line;
    if (install) tag_q[req_idx][way_q]     <= req_tag;
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: a write-back instance checked against a behavioural
// cache model (per-set recency stamps, line arrays, sparse memory), and a
// write-through instance exercised with directed literal checks.
module tb_assoc_cache;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // write-back instance
  logic        stall = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata, mem_addr;
  logic        cpu_ready, hit, busy, mem_read, mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  // write-through instance
  logic        w_cpu_read = 1'b0, w_cpu_write = 1'b0;
  logic [15:0] w_cpu_addr = '0, w_cpu_wdata = '0;
  logic [15:0] w_cpu_rdata, w_mem_addr;
  logic        w_cpu_ready, w_hit, w_busy, w_mem_read, w_mem_write;
  logic [63:0] w_mem_wdata;
  logic [63:0] w_mem_rdata = '0;
  logic        w_mem_ack = 1'b0;

  assoc_cache dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assoc_cache #(.WRITE_BACK(0)) dut_wt (
    .clk(clk), .reset_n(reset_n), .stall(1'b0),
    .cpu_read(w_cpu_read), .cpu_write(w_cpu_write), .cpu_addr(w_cpu_addr), .cpu_wdata(w_cpu_wdata),
    .cpu_rdata(w_cpu_rdata), .cpu_ready(w_cpu_ready), .hit(w_hit), .busy(w_busy),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata), .mem_ack(w_mem_ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory image: line at 0xNN0 holds 0xNN00..0xNN03, overridden by evictions.
  logic [15:0] mem_model [int];

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return {a[11:4], 4'h0, a[3:0]};
  endfunction

  function automatic logic [15:0] mem_word(input int a);
    if (mem_model.exists(a)) return mem_model[a];
    return pattern(16'(a));
  endfunction

  // Memory responders: ack on the third cycle a request is seen.
  int ack_cnt = 0, w_ack_cnt = 0;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (!reset_n || !(mem_read || mem_write)) begin
      ack_cnt = 0;
    end else begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        for (int k = 0; k < 4; k++) mem_rdata[k*16 +: 16] = mem_word(int'(mem_addr) + k);
        mem_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (w_mem_ack) begin
      w_mem_ack = 1'b0;
      w_ack_cnt = 0;
    end else if (!reset_n || !(w_mem_read || w_mem_write)) begin
      w_ack_cnt = 0;
    end else begin
      w_ack_cnt++;
      if (w_ack_cnt == 3) begin
        for (int k = 0; k < 4; k++) w_mem_rdata[k*16 +: 16] = pattern(w_mem_addr + 16'(k));
        w_mem_ack = 1'b1;
      end
    end
  end

  // Behavioural model of the write-back instance (4 sets x 2 ways x 4 words).
  logic [15:0] m_data  [4][2][4];
  int          m_tag   [4][2];
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  int          m_stamp [4][2];
  int          m_time;

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_stamp[s][w] = -w;   // way 0 youngest after reset
      end
    m_time = 0;
  endtask

  task automatic model_access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                              output bit h, output bit ev, output logic [15:0] ev_addr,
                              output logic [63:0] ev_line, output logic [15:0] fill_addr,
                              output logic [15:0] rd);
    int s, t, o, w;
    s = (int'(a) / 4) % 4;
    t = int'(a) / 16;
    o = int'(a) % 4;
    w = -1;
    ev = 1'b0; ev_addr = '0; ev_line = '0;
    fill_addr = a - 16'(o);
    for (int i = 0; i < 2; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    h = (w >= 0);
    if (h) begin
      rd = m_data[s][w][o];
    end else begin
      for (int i = 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = (m_stamp[s][0] < m_stamp[s][1]) ? 0 : 1;
      if (m_valid[s][w] && m_dirty[s][w]) begin
        ev = 1'b1;
        ev_addr = 16'((m_tag[s][w] * 4 + s) * 4);
        for (int k = 0; k < 4; k++) begin
          ev_line[k*16 +: 16] = m_data[s][w][k];
          mem_model[int'(ev_addr) + k] = m_data[s][w][k];
        end
      end
      for (int k = 0; k < 4; k++) m_data[s][w][k] = mem_word(int'(fill_addr) + k);
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = t;
      m_dirty[s][w] = 1'b0;
      rd = wr ? wd : m_data[s][w][o];
    end
    if (wr) begin
      m_data[s][w][o] = wd;
      m_dirty[s][w]   = 1'b1;
    end
    m_time++;
    m_stamp[s][w] = m_time;
  endtask

  // Compare process for the memory side of the write-back instance.
  logic [15:0] exp_wr_addr = '0, exp_fill_addr = '0, last_ev_addr = '0;
  logic [63:0] exp_wr_line = '0, last_ev_line = '0;
  int          n_ev = 0, n_fill = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("rd_wr_exclusive", mem_read & mem_write, 0);
      if (mem_write) begin
        n_ev++;
        last_ev_addr = mem_addr;
        last_ev_line = mem_wdata;
        check("evict_addr", mem_addr, exp_wr_addr);
        check("evict_line", mem_wdata, exp_wr_line);
        check("evict_busy", busy, 1);
      end
      if (mem_read) begin
        n_fill++;
        check("fill_addr", mem_addr, exp_fill_addr);
        check("fill_busy", busy, 1);
      end
    end
  end

  // One CPU request on the write-back instance, checked against the model.
  task automatic req(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                     output logic [15:0] got, output bit got_hit);
    bit h, ev;
    logic [15:0] ev_addr, fill_addr, rd;
    logic [63:0] ev_line;
    model_access(wr, a, wd, h, ev, ev_addr, ev_line, fill_addr, rd);
    exp_wr_addr = ev_addr;
    exp_wr_line = ev_line;
    exp_fill_addr = fill_addr;
    n_ev = 0;
    n_fill = 0;
    @(posedge clk); #1;
    cpu_read = !wr; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    got_hit = hit;
    got = cpu_rdata;
    check("hit_flag", hit, h);
    check("ready_on_request", cpu_ready, h);
    if (h) begin
      check("hit_rdata", cpu_rdata, rd);
    end else begin
      for (int i = 0; i < 40 && !cpu_ready; i++) @(negedge clk);
      check("respond_seen", cpu_ready, 1);
      check("respond_not_busy", busy, 0);
      check("respond_rdata", cpu_rdata, rd);
      got = cpu_rdata;
      check("evict_happened", n_ev > 0, ev);
      check("fill_happened", n_fill > 0, 1);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cpu_ready, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_rdata"}, cpu_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    bit          gh;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // cold read, then re-read hit
    req(0, 16'h0012, '0, got, gh);
    check("cold_read_data", got, 16'h0102);
    check("cold_read_missed", gh, 0);
    req(0, 16'h0012, '0, got, gh);
    check("reread_hit", gh, 1);
    check("reread_data", got, 16'h0102);

    // write hit then read back
    req(1, 16'h0011, 16'hBEEF, got, gh);
    check("write_hit_no_memwrite", n_ev, 0);
    req(0, 16'h0011, '0, got, gh);
    check("write_readback", got, 16'hBEEF);

    // LRU and dirty eviction in set 0
    req(0, 16'h0010, '0, got, gh);
    req(0, 16'h0020, '0, got, gh);
    req(1, 16'h0020, 16'h1234, got, gh);
    req(0, 16'h0010, '0, got, gh);
    req(0, 16'h0030, '0, got, gh);
    check("lru_evict_addr", last_ev_addr, 16'h0020);
    check("lru_evict_word0", last_ev_line[15:0], 16'h1234);
    check("lru_fill_addr", exp_fill_addr, 16'h0030);
    req(0, 16'h0010, '0, got, gh);
    check("mru_still_hits", gh, 1);
    check("mru_data", got, 16'h0100);

    // stalled write hit: no data, dirty or LRU change
    @(posedge clk); #1;
    stall = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0031; cpu_wdata = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_hit", hit, 1);
      check("stall_ready", cpu_ready, 1);
      check("stall_not_busy", busy, 0);
      if (i == 0) @(posedge clk);
    end
    @(posedge clk); #1;
    stall = 1'b0; cpu_write = 1'b0;
    // way holding 0x0030 must still be clean and least recent: plain fill, no evict
    req(0, 16'h0020, '0, got, gh);
    check("stall_no_evict", n_ev, 0);
    check("refill_sees_evicted_data", got, 16'h1234);

    // reset during a line fill
    exp_fill_addr = 16'h0054;
    n_fill = 0;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = 16'h0054;
    for (int i = 0; i < 10 && n_fill == 0; i++) @(negedge clk);
    check("fill_started", n_fill > 0, 1);
    @(posedge clk); #1;
    reset_n = 1'b0; cpu_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_kills_read", mem_read, 0);
    check("reset_kills_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_outputs("midreset");
    req(0, 16'h0054, '0, got, gh);
    check("abandoned_fill_misses", gh, 0);
    check("abandoned_fill_data", got, 16'h0504);

    // write miss with merge, then dirty eviction on conflict
    req(1, 16'h0041, 16'hAAAA, got, gh);
    check("write_miss_missed", gh, 0);
    check("write_miss_respond", got, 16'hAAAA);
    req(0, 16'h0041, '0, got, gh);
    check("write_miss_readback_hit", gh, 1);
    check("write_miss_readback", got, 16'hAAAA);
    req(0, 16'h0050, '0, got, gh);
    req(0, 16'h0060, '0, got, gh);
    check("dirty_evict_addr", last_ev_addr, 16'h0040);
    check("dirty_evict_word1", last_ev_line[31:16], 16'hAAAA);
    check("dirty_evict_word0", last_ev_line[15:0], 16'h0400);

    // write-through instance
    @(posedge clk); #1;
    w_cpu_read = 1'b1; w_cpu_addr = 16'h0013;
    for (int i = 0; i < 40 && !w_cpu_ready; i++) @(negedge clk);
    check("wt_fill_ready", w_cpu_ready, 1);
    check("wt_fill_data", w_cpu_rdata, 16'h0103);
    @(posedge clk); #1;
    w_cpu_read = 1'b0; w_cpu_write = 1'b1; w_cpu_wdata = 16'h5555;
    @(negedge clk);
    check("wt_write_hit", w_hit, 1);
    check("wt_write_not_ready", w_cpu_ready, 0);
    for (int i = 0; i < 10 && !w_mem_write; i++) @(negedge clk);
    check("wt_mem_write", w_mem_write, 1);
    check("wt_busy", w_busy, 1);
    check("wt_addr", w_mem_addr, 16'h0010);
    check("wt_word3", w_mem_wdata[63:48], 16'h5555);
    check("wt_word0", w_mem_wdata[15:0], 16'h0100);
    for (int i = 0; i < 10 && !w_cpu_ready; i++) begin
      @(negedge clk);
      if (!w_cpu_ready) check("wt_ready_waits_for_ack", w_busy | w_mem_ack, 1);
    end
    check("wt_respond", w_cpu_ready, 1);
    check("wt_respond_idle", w_busy, 0);
    check("wt_respond_data", w_cpu_rdata, 16'h5555);
    @(posedge clk); #1;
    w_cpu_write = 1'b0; w_cpu_read = 1'b1;
    @(negedge clk);
    check("wt_reread_hit", w_hit, 1);
    check("wt_reread_data", w_cpu_rdata, 16'h5555);
    @(posedge clk); #1;
    w_cpu_read = 1'b0;

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
